// File: rtl/bmp280_pkg.sv
// bmp280_pkg: states, register map and tx helper for the BMP280 sampler.
// ID_REQ/ID_WAIT exist only when BMP280_ID_CHECK_EN is defined.
package bmp280_pkg;
  typedef enum logic [3:0] {
    IDLE,
`ifdef BMP280_ID_CHECK_EN
    ID_REQ,
    ID_WAIT,
`endif
    CFG_REQ,
    CFG_WAIT,
    T_REQ,
    T_WAIT,
    P_REQ,
    P_WAIT,
    PUBLISH,
    DELAY,
    ERROR
  } bmp280_state_t;
  localparam logic [7:0] REG_ID = 8'hD0;
  localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
  localparam logic [7:0] REG_PRESS_MSB = 8'hF7;
  localparam logic [7:0] REG_TEMP_MSB = 8'hFA;
  localparam logic [7:0] CHIP_ID = 8'h58;
  localparam logic [1:0] WORDS_4 = 2'b11;
  localparam logic [1:0] WORDS_2 = 2'b01;
  function automatic logic [3:0][7:0] tx_bytes(input logic [7:0] b0, input logic [7:0] b1);
    return {8'h00, 8'h00, b1, b0};
  endfunction
endpackage

// File: rtl/bmp280_cycle_counter.sv
// bmp280_cycle_counter: loadable up-counter with clear and terminal-count match.
module bmp280_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : load ? load_val : inc ? cnt + W'(1) : cnt;
  assign hit = cnt == term;
endmodule

// File: rtl/bmp280_sampler.sv
// bmp280_sampler: configures the BMP280 then periodically burst-reads raw T/P over the SPI controller.
// Define BMP280_ID_CHECK_EN to verify the chip ID before configuration.
module bmp280_sampler
  import bmp280_pkg::*;
#(
  parameter int         SAMPLE_DIV = 100000,
  parameter logic [7:0] CTRL_MEAS  = 8'h27,
  parameter int         TIMEOUT    = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic            spi_start,
  output logic [1:0]      spi_words,
  output logic            spi_tied_ss,
  output logic [3:0][7:0] spi_tx_data,
  input  logic [3:0][7:0] spi_rx_data,
  input  logic            spi_done,
  output logic [19:0]     temp_raw,
  output logic [19:0]     press_raw,
  output logic            sample_valid,
  output logic            busy,
  output logic            error
);
  localparam int CW = $clog2((SAMPLE_DIV > TIMEOUT ? SAMPLE_DIV : TIMEOUT) + 1);
  bmp280_state_t state, nxt;
  logic done_q, cfg_done, cmpl, hit, counting, is_req, unused;
  logic [19:0] t_sh, rx_raw;
  logic [3:0][7:0] req_tx;
`ifdef BMP280_ID_CHECK_EN
  localparam bmp280_state_t FIRST = ID_REQ;
  assign counting = state inside {ID_WAIT, CFG_WAIT, T_WAIT, P_WAIT, DELAY};
  assign is_req = nxt inside {ID_REQ, CFG_REQ, T_REQ, P_REQ};
`else
  localparam bmp280_state_t FIRST = CFG_REQ;
  assign counting = state inside {CFG_WAIT, T_WAIT, P_WAIT, DELAY};
  assign is_req = nxt inside {CFG_REQ, T_REQ, P_REQ};
`endif
  // A done level already high when the request goes out is not a completion
  assign cmpl = spi_done & ~done_q;
  assign rx_raw = {spi_rx_data[1], spi_rx_data[2], spi_rx_data[3][7:4]};
  assign unused = ^{spi_rx_data[0], spi_rx_data[3][3:0]};
  assign spi_tied_ss = 1'b1;
  assign req_tx = nxt == CFG_REQ ? tx_bytes(REG_CTRL_MEAS & 8'h7F, CTRL_MEAS) :
                  nxt == T_REQ   ? tx_bytes(REG_TEMP_MSB, 8'h00) :
                  nxt == P_REQ   ? tx_bytes(REG_PRESS_MSB, 8'h00) : tx_bytes(REG_ID, 8'h00);
  // One counter serves both the DELAY period and the per-transaction timeout
  bmp280_cycle_counter #(.W(CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(!counting),
    .load(1'b0),
    .inc(1'b1),
    .load_val('0),
    .term(state == DELAY ? CW'(SAMPLE_DIV - 1) : CW'(TIMEOUT - 1)),
    .hit(hit)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = !enable ? IDLE : cfg_done ? T_REQ : FIRST;
`ifdef BMP280_ID_CHECK_EN
      ID_REQ:   nxt = ID_WAIT;
      ID_WAIT:  nxt = cmpl ? (spi_rx_data[1] != CHIP_ID ? ERROR : enable ? CFG_REQ : IDLE) : hit ? ERROR : ID_WAIT;
`endif
      CFG_REQ:  nxt = CFG_WAIT;
      CFG_WAIT: nxt = cmpl ? (enable ? T_REQ : IDLE) : hit ? ERROR : CFG_WAIT;
      T_REQ:    nxt = T_WAIT;
      T_WAIT:   nxt = cmpl ? (enable ? P_REQ : IDLE) : hit ? ERROR : T_WAIT;
      P_REQ:    nxt = P_WAIT;
      P_WAIT:   nxt = cmpl ? (enable ? PUBLISH : IDLE) : hit ? ERROR : P_WAIT;
      PUBLISH:  nxt = DELAY;
      DELAY:    nxt = !enable ? IDLE : hit ? T_REQ : DELAY;
      default:  nxt = ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      done_q <= 1'b0;
      cfg_done <= 1'b0;
      t_sh <= '0;
      spi_start <= 1'b0;
      spi_words <= '0;
      spi_tx_data <= '0;
      temp_raw <= '0;
      press_raw <= '0;
      sample_valid <= 1'b0;
      busy <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nxt;
      done_q <= spi_done;
      spi_start <= is_req;
      sample_valid <= nxt == PUBLISH;
      busy <= !(nxt inside {IDLE, ERROR});
      error <= nxt == ERROR;
      if (state == CFG_WAIT && cmpl) cfg_done <= 1'b1;
      if (state == T_WAIT && cmpl) t_sh <= rx_raw;
      if (nxt == PUBLISH) begin
        temp_raw <= t_sh;
        press_raw <= rx_raw;
      end
      if (is_req) begin
        spi_tx_data <= req_tx;
        spi_words <= nxt == CFG_REQ ? WORDS_2 : WORDS_4;
      end
    end
  end
endmodule

// File: tb/tb_bmp280_sampler.sv
// tb_bmp280_sampler: SPI controller model, sample scoreboard and corner-case sequences.
// Adds the chip-ID sequences when BMP280_ID_CHECK_EN is defined.
module tb_bmp280_sampler;
  localparam int SD = 20, TO = 32, NV = 4, BOUND = 400;
  typedef struct { logic [7:0] t1, t2, t3, p1, p2, p3; logic [19:0] et, ep; } vec_t;
  typedef struct { logic [7:0] tx0, tx1; logic [1:0] words; } txn_t;
  typedef struct { logic [19:0] t, p; } smp_t;
  logic clk = 0, rst = 0, enable = 0, spi_done = 0;
  logic spi_start, spi_tied_ss, sample_valid, busy, error;
  logic [1:0] spi_words;
  logic [3:0][7:0] spi_tx_data, spi_rx_data = '0;
  logic [19:0] temp_raw, press_raw;
  vec_t vec [NV];
  txn_t log_q[$];
  smp_t sb[$];
  int n_cmp = 0, n_bad = 0, vi = 0, lat = 3;
  logic model_on = 1, hold = 0;
  logic [7:0] id_val = 8'h58;

  bmp280_sampler #(.SAMPLE_DIV(SD), .CTRL_MEAS(8'h27), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .spi_start(spi_start), .spi_words(spi_words),
    .spi_tied_ss(spi_tied_ss), .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
    .spi_done(spi_done), .temp_raw(temp_raw), .press_raw(press_raw),
    .sample_valid(sample_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Controller model: logs each request, answers after lat cycles with a done pulse (or held level)
  initial begin
    logic pend, prev;
    int cd;
    txn_t cur;
    smp_t s;
    pend = 0; prev = 0; cd = 0;
    forever begin
      @(negedge clk);
      if (prev) chk("start_pulse", spi_start, 0);
      prev = spi_start;
      if (!rst) begin
        pend = 0;
        spi_done = 0;
      end else if (spi_done && !hold) spi_done = 0;
      else if (pend && model_on && !spi_done) begin
        if (cd > 0) cd--;
        else begin
          chk("tx_stable", spi_tx_data[0], cur.tx0);
          spi_rx_data = {8'h00, 8'h00, 8'h00, 8'hEE};
          if (cur.tx0 == 8'hFA) spi_rx_data = {vec[vi].t3, vec[vi].t2, vec[vi].t1, 8'hEE};
          else if (cur.tx0 == 8'hF7) begin
            spi_rx_data = {vec[vi].p3, vec[vi].p2, vec[vi].p1, 8'hEE};
            s.t = vec[vi].et; s.p = vec[vi].ep;
            sb.push_back(s);
            vi = (vi + 1) % NV;
          end else if (cur.tx0 == 8'hD0) spi_rx_data[1] = id_val;
          spi_done = 1;
          pend = 0;
        end
      end
      if (spi_start && rst) begin
        cur.tx0 = spi_tx_data[0]; cur.tx1 = spi_tx_data[1]; cur.words = spi_words;
        log_q.push_back(cur);
        pend = 1;
        cd = lat;
      end
    end
  end

  initial begin
    smp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("temp_raw", temp_raw, e.t);
          chk("press_raw", press_raw, e.p);
        end
      end
    end
  end

  task automatic wait_start(input string nm);
    int k; k = 0;
    do begin @(negedge clk); k++; end while (!spi_start && k < BOUND);
    chk(nm, spi_start, 1);
  endtask

  task automatic wait_sv(input string nm);
    int k; k = 0;
    do begin @(negedge clk); k++; end while (!sample_valid && k < BOUND);
    chk(nm, sample_valid, 1);
  endtask

  task automatic check_gap();
    int k; k = 0;
    do begin
      @(negedge clk); k++;
      if (k == 1) chk("valid_one_cycle", sample_valid, 0);
    end while (!spi_start && k < BOUND);
    chk("delay_gap", k, SD + 1);
  endtask

  task automatic expect_tx(input string nm, input logic [7:0] tx0, input logic [7:0] tx1, input logic [1:0] w);
    int k; txn_t t; k = 0;
    while (log_q.size() == 0 && k < BOUND) begin @(negedge clk); k++; end
    chk({nm, "_seen"}, log_q.size() > 0, 1);
    if (log_q.size() > 0) begin
      t = log_q.pop_front();
      chk({nm, "_tx0"}, t.tx0, tx0);
      chk({nm, "_tx1"}, t.tx1, tx1);
      chk({nm, "_words"}, t.words, w);
    end
  endtask

  task automatic expect_cfg();
`ifdef BMP280_ID_CHECK_EN
    expect_tx("id", 8'hD0, 8'h00, 2'b11);
`endif
    expect_tx("cfg", 8'h74, 8'h27, 2'b01);
  endtask

  initial begin
    int k, starts, svs;
    vec[0] = '{8'h80, 8'h00, 8'h00, 8'h65, 8'h5A, 8'hC0, 20'h80000, 20'h655AC};
    vec[1] = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 20'h12345, 20'hABCDE};
    vec[2] = '{8'hFF, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h0F, 20'hFFFFF, 20'h00000};
    vec[3] = '{8'h7E, 8'h21, 8'h9B, 8'h01, 8'h02, 8'h30, 20'h7E219, 20'h01023};
    enable = 1;
    repeat (3) @(negedge clk);
    chk("rst_start", spi_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_temp", temp_raw, 0);
    chk("rst_press", press_raw, 0);
    chk("rst_ss", spi_tied_ss, 1);
    chk("rst_words", spi_words, 0);
    chk("rst_tx", spi_tx_data, 0);
    rst = 1;
    expect_cfg();
    expect_tx("t0", 8'hFA, 8'h00, 2'b11);
    expect_tx("p0", 8'hF7, 8'h00, 2'b11);
    for (int i = 0; i < NV; i++) begin
      wait_sv("sample");
      check_gap();
      chk("busy_run", busy, 1);
    end
    // done left high from P must not complete the following T
    wait_start("p_hold");
    hold = 1;
    wait_sv("sample_hold");
    log_q.delete();
    wait_start("t_hold");
    repeat (3 * lat + 6) @(negedge clk);
    chk("hold_no_new_txn", log_q.size(), 1);
    chk("hold_busy", busy, 1);
    chk("hold_tx", spi_tx_data[0], 8'hFA);
    hold = 0;
    expect_tx("t_hold", 8'hFA, 8'h00, 2'b11);
    expect_tx("p_after_hold", 8'hF7, 8'h00, 2'b11);
    wait_sv("sample_after_hold");
    wait_start("t_drop");
    @(negedge clk);
    enable = 0;
    starts = 0; svs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("drop_still_busy", busy, 1);
      starts += int'(spi_start);
      svs += int'(sample_valid);
    end
    chk("drop_no_start", starts, 0);
    chk("drop_no_valid", svs, 0);
    chk("drop_idle", busy, 0);
    log_q.delete();
    enable = 1;
    expect_tx("t_reenter", 8'hFA, 8'h00, 2'b11);
    wait_sv("sample_reenter");
    wait_start("t_mid");
    wait_start("p_mid");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mid_rst_temp", temp_raw, 0);
    chk("mid_rst_press", press_raw, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", spi_start, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_tx", spi_tx_data, 0);
    chk("mid_rst_words", spi_words, 0);
    chk("mid_rst_ss", spi_tied_ss, 1);
    log_q.delete();
    rst = 1;
    expect_cfg();
    expect_tx("t_after_rst", 8'hFA, 8'h00, 2'b11);
    wait_sv("sample_after_rst");
    model_on = 0;
    wait_start("t_timeout");
    k = 0;
    do begin @(negedge clk); k++; end while (!error && k < BOUND);
    chk("timeout_gap", k, TO + 1);
    chk("err_busy", busy, 0);
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      starts += int'(spi_start);
    end
    chk("err_no_start", starts, 0);
    chk("err_sticky", error, 1);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_clears_err", error, 0);
    model_on = 1;
`ifdef BMP280_ID_CHECK_EN
    id_val = 8'h60;
    log_q.delete();
    rst = 1;
    expect_tx("id_bad", 8'hD0, 8'h00, 2'b11);
    k = 0;
    do begin @(negedge clk); k++; end while (!error && k < BOUND);
    chk("id_err", error, 1);
    chk("id_err_busy", busy, 0);
    chk("id_no_cfg", log_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
